rename_rat: RTL and testbench
=============================

RENAME_RAT -- requirements
Module: rename_rat

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: rename_valid  input  1  rename request this cycle.
REQ-004 SHALL have ports: rs1_arch, rs2_arch  input  5 each  source architectural regs.
REQ-005 SHALL have ports: rd_arch  input  5, rd_write  input  1  destination reg and its write-enable.
REQ-006 SHALL have port: free_tag  input  8  next free physical tag from the free list.
REQ-007 SHALL have ports: save_state  input  1, save_page  input  3  checkpoint request and slot.
REQ-008 SHALL have ports: restore_state  input  1, restore_page  input  3  rollback request and slot.
REQ-009 SHALL have ports: rs1_phys, rs2_phys  output  8 each  renamed sources, registered.
REQ-010 SHALL have ports: rd_new_phys, rd_old_phys  output  8 each  new and superseded dest tags, registered.
REQ-011 SHALL have port: out_valid  output  1  outputs valid, 1-cycle pulse per rename.
REQ-012 SHALL have port: free_consume  output  1  combinational pop strobe to the free list.
REQ-013 SHALL have port: release_valid  output  1  rd_old_phys valid for return to the free list.
REQ-014 SHALL have ports: ckpt_valid  output  8  per-page valid mask; restore_err  output  1  1-cycle error pulse.

Function
REQ-015 SHALL hold a 32-entry x 8-bit map table plus 8 checkpoint copies of it.
REQ-016 Arch reg 0 SHALL always map to tag 0; rename with rd_arch=0 SHALL not update the table, assert free_consume or assert release_valid.
REQ-017 On accepted rename, sources SHALL be read from the table before this cycle's rd update (no self-bypass); results appear next cycle with out_valid=1 (latency 1).
REQ-018 On accepted rename with rd_write=1 and rd_arch!=0:
- free_consume=1 in the same cycle
- table[rd_arch] <= free_tag
- next cycle: rd_new_phys=free_tag, rd_old_phys=previous table[rd_arch], release_valid=1.
REQ-019 On accepted rename with rd_write=0 or rd_arch=0: rd_new_phys=0, rd_old_phys=0, release_valid=0; out_valid still 1.
REQ-020 save_state SHALL copy the table as it stands after this cycle's rename update into page save_page, and set ckpt_valid[save_page]; an existing page SHALL be overwritten.
REQ-021 restore_state with ckpt_valid[restore_page]=1 SHALL load the table from that page in one cycle; the page remains valid.
REQ-022 restore_state SHALL have priority over save_state and rename_valid:
- the rename in that cycle is dropped: free_consume=0, and next cycle out_valid=0
- the save in that cycle is ignored.
REQ-023 restore_state with ckpt_valid[restore_page]=0 SHALL leave the table unchanged and pulse restore_err the next cycle; the simultaneous rename and save SHALL also be dropped.
REQ-024 In cycles without an accepted rename, out_valid and release_valid SHALL be 0; data outputs hold their last values.
REQ-025 Physical tags SHALL be treated as opaque 8-bit values; no arithmetic is performed on them.

Reset
REQ-026 Asserting reset SHALL immediately set table[i]=i for i=0..31, consistent with a free list holding tags 32..159.
REQ-027 Asserting reset SHALL clear ckpt_valid to 0 and drive all outputs to 0; checkpoint contents need not be cleared.
REQ-028 Reset asserted mid-rename SHALL discard the rename.

Verification
REQ-029 Reset, then rename rs1=3, rs2=5, rd=3, rd_write=1, free_tag=32 -> next cycle rs1_phys=3, rs2_phys=5, rd_new_phys=32, rd_old_phys=3, release_valid=1.
REQ-030 Follow REQ-029 with rename rs1=3, rd=3, free_tag=33 -> rs1_phys=32, rd_old_phys=32, rd_new_phys=33.
REQ-031 Rename rd=0, rd_write=1, free_tag=40 -> free_consume=0, release_valid=0, and a later read of rs1=0 returns 0.
REQ-032 Save page 2 with rename rd=7 <- 50 in the same cycle; then rename rd=7 <- 51; then restore page 2 -> ckpt_valid=0x04, and a subsequent read of rs1=7 returns 50.
REQ-033 Restore page 5 while invalid, together with rename_valid -> restore_err=1, out_valid=0, table unchanged.
REQ-034 Assert reset after several renames and saves -> ckpt_valid=0, all outputs 0, and a read of rs1=9 returns 9.

Source files
------------

// File: rtl/rename_rat.sv
// Register alias table: maps 32 architectural regs to 8-bit physical tags, with 8 checkpoint pages.
// Latency: renamed tags registered, 1 cycle; free_consume is combinational in the request cycle.
// Backpressure: none; restore_state drops any same-cycle rename and save.
module rename_rat (
    input  logic       clk,
    input  logic       reset,
    input  logic       rename_valid,
    input  logic [4:0] rs1_arch,
    input  logic [4:0] rs2_arch,
    input  logic [4:0] rd_arch,
    input  logic       rd_write,
    input  logic [7:0] free_tag,
    input  logic       save_state,
    input  logic [2:0] save_page,
    input  logic       restore_state,
    input  logic [2:0] restore_page,
    output logic [7:0] rs1_phys,
    output logic [7:0] rs2_phys,
    output logic [7:0] rd_new_phys,
    output logic [7:0] rd_old_phys,
    output logic       out_valid,
    output logic       free_consume,
    output logic       release_valid,
    output logic [7:0] ckpt_valid,
    output logic       restore_err
);

    logic [7:0] map_q    [32];
    logic [7:0] map_next [32];
    logic [7:0] ckpt_q   [8][32];

    logic accept;
    logic do_write;
    logic restore_ok;
    logic restore_bad;
    logic save_ok;

    assign accept       = rename_valid & ~restore_state & ~reset;
    assign do_write     = accept & rd_write & (rd_arch != 5'd0);
    assign restore_ok   = restore_state & ckpt_valid[restore_page];
    assign restore_bad  = restore_state & ~ckpt_valid[restore_page];
    assign save_ok      = save_state & ~restore_state & ~reset;
    assign free_consume = do_write;

    // Table after this cycle's update; also the image captured by a save.
    always_comb begin
        map_next = map_q;
        if (restore_ok) begin
            map_next = ckpt_q[restore_page];
        end else if (do_write) begin
            map_next[rd_arch] = free_tag;
        end
        map_next[0] = 8'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                map_q[i] <= 8'(i);
            end
        end else begin
            map_q <= map_next;
        end
    end

    // Checkpoint storage needs no reset; ckpt_valid gates every use.
    always_ff @(posedge clk) begin
        if (save_ok) begin
            ckpt_q[save_page] <= map_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_phys      <= 8'd0;
            rs2_phys      <= 8'd0;
            rd_new_phys   <= 8'd0;
            rd_old_phys   <= 8'd0;
            out_valid     <= 1'b0;
            release_valid <= 1'b0;
            ckpt_valid    <= 8'd0;
            restore_err   <= 1'b0;
        end else begin
            out_valid     <= accept;
            release_valid <= do_write;
            restore_err   <= restore_bad;
            if (save_ok) begin
                ckpt_valid[save_page] <= 1'b1;
            end
            // Sources read the pre-update table: no bypass from this cycle's rd.
            if (accept) begin
                rs1_phys    <= map_q[rs1_arch];
                rs2_phys    <= map_q[rs2_arch];
                rd_new_phys <= do_write ? free_tag : 8'd0;
                rd_old_phys <= do_write ? map_q[rd_arch] : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_rename_rat.sv
// Directed bench for rename_rat: hand-computed expectations checked with immediate assertions.
module tb_rename_rat;

    logic       clk = 1'b0;
    logic       reset;
    logic       rename_valid;
    logic [4:0] rs1_arch, rs2_arch, rd_arch;
    logic       rd_write;
    logic [7:0] free_tag;
    logic       save_state;
    logic [2:0] save_page;
    logic       restore_state;
    logic [2:0] restore_page;
    logic [7:0] rs1_phys, rs2_phys, rd_new_phys, rd_old_phys;
    logic       out_valid, free_consume, release_valid;
    logic [7:0] ckpt_valid;
    logic       restore_err;

    int vectors = 0;
    int miscompares = 0;

    rename_rat dut (
        .clk           (clk),
        .reset         (reset),
        .rename_valid  (rename_valid),
        .rs1_arch      (rs1_arch),
        .rs2_arch      (rs2_arch),
        .rd_arch       (rd_arch),
        .rd_write      (rd_write),
        .free_tag      (free_tag),
        .save_state    (save_state),
        .save_page     (save_page),
        .restore_state (restore_state),
        .restore_page  (restore_page),
        .rs1_phys      (rs1_phys),
        .rs2_phys      (rs2_phys),
        .rd_new_phys   (rd_new_phys),
        .rd_old_phys   (rd_old_phys),
        .out_valid     (out_valid),
        .free_consume  (free_consume),
        .release_valid (release_valid),
        .ckpt_valid    (ckpt_valid),
        .restore_err   (restore_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rename_valid  = 1'b0;
        rs1_arch      = 5'd0;
        rs2_arch      = 5'd0;
        rd_arch       = 5'd0;
        rd_write      = 1'b0;
        free_tag      = 8'd0;
        save_state    = 1'b0;
        save_page     = 3'd0;
        restore_state = 1'b0;
        restore_page  = 3'd0;
    endtask

    task automatic rename(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic wr, input logic [7:0] tag);
        rename_valid = 1'b1;
        rs1_arch     = r1;
        rs2_arch     = r2;
        rd_arch      = rd;
        rd_write     = wr;
        free_tag     = tag;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rs1"},  32'(rs1_phys), 32'd0);
        check({tag, "_rs2"},  32'(rs2_phys), 32'd0);
        check({tag, "_new"},  32'(rd_new_phys), 32'd0);
        check({tag, "_old"},  32'(rd_old_phys), 32'd0);
        check({tag, "_ov"},   32'(out_valid), 32'd0);
        check({tag, "_fc"},   32'(free_consume), 32'd0);
        check({tag, "_rel"},  32'(release_valid), 32'd0);
        check({tag, "_ckv"},  32'(ckpt_valid), 32'd0);
        check({tag, "_rerr"}, 32'(restore_err), 32'd0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #12;
        check_zero_outputs("reset");
        reset = 1'b0;
        #6;

        // r3 <- 32 with sources r3,r5
        rename(5'd3, 5'd5, 5'd3, 1'b1, 8'd32);
        #1 check("r1_fc", 32'(free_consume), 32'd1);
        tick();
        check("r1_ov",  32'(out_valid), 32'd1);
        check("r1_rs1", 32'(rs1_phys), 32'd3);
        check("r1_rs2", 32'(rs2_phys), 32'd5);
        check("r1_new", 32'(rd_new_phys), 32'd32);
        check("r1_old", 32'(rd_old_phys), 32'd3);
        check("r1_rel", 32'(release_valid), 32'd1);

        // r3 <- 33, reading r3 sees 32
        rename(5'd3, 5'd0, 5'd3, 1'b1, 8'd33);
        tick();
        check("r2_rs1", 32'(rs1_phys), 32'd32);
        check("r2_rs2", 32'(rs2_phys), 32'd0);
        check("r2_new", 32'(rd_new_phys), 32'd33);
        check("r2_old", 32'(rd_old_phys), 32'd32);

        // Idle cycle: strobes drop, data holds
        idle();
        tick();
        check("idle_ov",  32'(out_valid), 32'd0);
        check("idle_rel", 32'(release_valid), 32'd0);
        check("idle_new", 32'(rd_new_phys), 32'd33);

        // rd=0 write is a no-op
        rename(5'd0, 5'd3, 5'd0, 1'b1, 8'd40);
        #1 check("z_fc", 32'(free_consume), 32'd0);
        tick();
        check("z_ov",  32'(out_valid), 32'd1);
        check("z_rel", 32'(release_valid), 32'd0);
        check("z_new", 32'(rd_new_phys), 32'd0);
        check("z_old", 32'(rd_old_phys), 32'd0);
        check("z_rs2", 32'(rs2_phys), 32'd33);
        rename(5'd0, 5'd0, 5'd0, 1'b0, 8'd0);
        tick();
        check("z_rd0", 32'(rs1_phys), 32'd0);

        // Save page 2 capturing r7 <- 50 from the same cycle
        rename(5'd7, 5'd0, 5'd7, 1'b1, 8'd50);
        save_state = 1'b1;
        save_page  = 3'd2;
        tick();
        check("s_old", 32'(rd_old_phys), 32'd7);
        check("s_new", 32'(rd_new_phys), 32'd50);
        check("s_ckv", 32'(ckpt_valid), 32'h04);
        save_state = 1'b0;
        rename(5'd7, 5'd0, 5'd7, 1'b1, 8'd51);
        tick();
        check("s2_rs1", 32'(rs1_phys), 32'd50);
        check("s2_old", 32'(rd_old_phys), 32'd50);
        check("s2_new", 32'(rd_new_phys), 32'd51);

        // Restore page 2; simultaneous rename and save to page 3 are dropped
        rename(5'd7, 5'd0, 5'd7, 1'b1, 8'd60);
        save_state    = 1'b1;
        save_page     = 3'd3;
        restore_state = 1'b1;
        restore_page  = 3'd2;
        #1 check("rs_fc", 32'(free_consume), 32'd0);
        tick();
        check("rs_ov",   32'(out_valid), 32'd0);
        check("rs_rel",  32'(release_valid), 32'd0);
        check("rs_rerr", 32'(restore_err), 32'd0);
        check("rs_ckv",  32'(ckpt_valid), 32'h04);
        idle();
        rename(5'd7, 5'd3, 5'd0, 1'b0, 8'd0);
        tick();
        check("rs_r7", 32'(rs1_phys), 32'd50);
        check("rs_r3", 32'(rs2_phys), 32'd33);

        // Restore from invalid page 5 with rename and save
        rename(5'd4, 5'd0, 5'd4, 1'b1, 8'd70);
        save_state    = 1'b1;
        save_page     = 3'd1;
        restore_state = 1'b1;
        restore_page  = 3'd5;
        #1 check("bad_fc", 32'(free_consume), 32'd0);
        tick();
        check("bad_rerr", 32'(restore_err), 32'd1);
        check("bad_ov",   32'(out_valid), 32'd0);
        check("bad_ckv",  32'(ckpt_valid), 32'h04);
        idle();
        rename(5'd4, 5'd7, 5'd0, 1'b0, 8'd0);
        tick();
        check("bad_rerr_pulse", 32'(restore_err), 32'd0);
        check("bad_r4", 32'(rs1_phys), 32'd4);
        check("bad_r7", 32'(rs2_phys), 32'd50);

        // Build state, then reset in the middle of a rename
        rename(5'd9, 5'd0, 5'd9, 1'b1, 8'd80);
        save_state = 1'b1;
        save_page  = 3'd6;
        tick();
        check("pre_ckv", 32'(ckpt_valid), 32'h44);
        save_state = 1'b0;
        rename(5'd9, 5'd0, 5'd9, 1'b1, 8'd81);
        reset = 1'b1;
        #1 check_zero_outputs("rst_async");
        tick();
        check_zero_outputs("rst_held");
        reset = 1'b0;
        #2;
        rename(5'd9, 5'd3, 5'd0, 1'b0, 8'd0);
        tick();
        check("post_ov", 32'(out_valid), 32'd1);
        check("post_r9", 32'(rs1_phys), 32'd9);
        check("post_r3", 32'(rs2_phys), 32'd3);
        check("post_ckv", 32'(ckpt_valid), 32'd0);

        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
